// File: rtl/steer_en_gen.sv
// steer_en_gen: rider-presence / steer-enable FSM (IDLE/WAIT/STEER) with settle timer and debounced rider-off.
// Optional load-cell range fault check is compiled in when LD_FAULT_CHK_EN is defined.
module steer_en_gen #(
  parameter int                FAST_SIM         = 1,
  parameter int                LD_W             = 12,
  parameter logic [LD_W-1:0]   MIN_RIDER_WT     = 12'h200,
  parameter logic [7:0]        WT_HYSTERESIS    = 8'h40,
  parameter int                DIFF_WAIT_SHIFT  = 2,
  parameter int                DIFF_STEER_SHIFT = 4,
  parameter int unsigned       TMR_CYCLES       = (FAST_SIM != 0) ? 16384 : 67108864,
  parameter int                OFF_DEBOUNCE     = 4,
  parameter int                FAULT_SAMPLES    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      steer_state,
  output logic            ld_fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] STEER = 2'd2;

  localparam int SW = LD_W + 1;
  localparam int TW = $clog2(TMR_CYCLES);
  localparam int DW = $clog2(OFF_DEBOUNCE + 1);

  localparam logic [SW-1:0] LO_THR  = SW'(MIN_RIDER_WT) - SW'(WT_HYSTERESIS);
  localparam logic [SW-1:0] HI_THR  = SW'(MIN_RIDER_WT) + SW'(WT_HYSTERESIS);
  localparam logic [TW-1:0] TMR_MAX = TW'(TMR_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(OFF_DEBOUNCE);
  localparam logic [DW-1:0] DB_ARM  = DW'(OFF_DEBOUNCE - 1);

  logic [1:0]      state_q, state_d, fsm_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   db_q, db_d;
  logic            en_steer_q, rider_off_q;
  logic            wait_clr, fault_force;

  logic [SW-1:0]   sum;
  logic [LD_W-1:0] diff;
  logic            sum_lt_min, sum_gt_min, diff_gt_wait, diff_gt_steer;
  logic            tmr_full, off_det;

  assign sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
  assign sum_lt_min    = (sum < LO_THR);
  assign sum_gt_min    = (sum > HI_THR);
  assign diff_gt_wait  = ({1'b0, diff} > (sum >> DIFF_WAIT_SHIFT));
  assign diff_gt_steer = ({1'b0, diff} > (sum - (sum >> DIFF_STEER_SHIFT)));
  assign tmr_full      = (tmr_q == TMR_MAX);
  assign off_det       = ld_vld & sum_lt_min & (db_q == DB_ARM);

  always_comb begin
    fsm_d    = state_q;
    wait_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_vld && sum_gt_min) fsm_d = WAIT;
      end
      WAIT: begin
        if (ld_vld) begin
          if (off_det)           fsm_d    = IDLE;
          else if (diff_gt_wait) wait_clr = 1'b1;
          else if (tmr_full)     fsm_d    = STEER;
        end
      end
      STEER: begin
        if (ld_vld) begin
          if (off_det)            fsm_d = IDLE;
          else if (diff_gt_steer) fsm_d = WAIT;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_d = fault_force ? IDLE : fsm_d;

`ifdef LD_FAULT_CHK_EN
  localparam int FW = $clog2(FAULT_SAMPLES + 1);
  localparam logic [FW-1:0] F_MAX = FW'(FAULT_SAMPLES);
  localparam logic [FW-1:0] F_ARM = FW'(FAULT_SAMPLES - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ld_fault_q, ld_fault_d, oor, fault_trip;

  assign oor        = (lft_ld == '0) | (lft_ld == '1) | (rght_ld == '0) | (rght_ld == '1);
  assign fault_trip = ld_vld & oor & (fcnt_q >= F_ARM) & (state_q != IDLE);

  always_comb begin
    fcnt_d     = fcnt_q;
    ld_fault_d = ld_fault_q;
    if (ld_vld) begin
      if (!oor) begin
        fcnt_d     = '0;
        ld_fault_d = 1'b0;
      end else begin
        if (fcnt_q != F_MAX) fcnt_d = fcnt_q + 1'b1;
        if (fault_trip)      ld_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q     <= '0;
      ld_fault_q <= 1'b0;
    end else begin
      fcnt_q     <= fcnt_d;
      ld_fault_q <= ld_fault_d;
    end
  end

  // An active fault pins the FSM in IDLE; the clearing sample itself still holds IDLE.
  assign fault_force = ld_fault_q | fault_trip;
  assign ld_fault    = ld_fault_q;
`else
  assign fault_force = 1'b0;
  assign ld_fault    = 1'b0;
`endif

  always_comb begin
    db_d = db_q;
    if (state_d != state_q) begin
      db_d = '0;
    end else if (ld_vld) begin
      if (!sum_lt_min)          db_d = '0;
      else if (db_q != DB_MAX)  db_d = db_q + 1'b1;
    end
  end

  always_comb begin
    if (((state_d == WAIT) && (state_q != WAIT)) || wait_clr) tmr_d = '0;
    else if (!tmr_full)                                        tmr_d = tmr_q + 1'b1;
    else                                                       tmr_d = tmr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      db_q        <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      db_q        <= db_d;
      en_steer_q  <= (state_d == STEER);
      rider_off_q <= (state_d == IDLE);
    end
  end

  assign en_steer    = en_steer_q;
  assign rider_off   = rider_off_q;
  assign steer_state = state_q;

endmodule

// File: tb/tb_steer_en_gen.sv
// Randomized/directed bench for steer_en_gen against an integer reference model of the rider-presence rules.
// Fault expectations follow LD_FAULT_CHK_EN when the bench is built with it.
module tb_steer_en_gen;

  localparam int T      = 16384;
  localparam int LO     = 'h1C0;
  localparam int HI     = 'h240;
  localparam int OFF_DB = 4;
  localparam int F_N    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] lft = '0, rght = '0;
  logic        vld = 1'b0;
  logic        en_steer, rider_off, ld_fault;
  logic [1:0]  steer_state;
  logic [4:0]  obs;

  int vecs = 0, errs = 0, cyc = 0;

  // model state: st 0=IDLE 1=WAIT 2=STEER
  int m_st, m_tmr, m_db, m_fc;
  bit m_flt;

  steer_en_gen #(.FAST_SIM(1), .LD_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .lft_ld(lft), .rght_ld(rght), .ld_vld(vld),
    .en_steer(en_steer), .rider_off(rider_off), .steer_state(steer_state), .ld_fault(ld_fault)
  );

  always #5 clk = ~clk;
  assign obs = {ld_fault, steer_state, rider_off, en_steer};

  function automatic void model_reset();
    m_st = 0; m_tmr = 0; m_db = 0; m_fc = 0; m_flt = 0;
  endfunction

  function automatic void model_step(int l, int r, bit v);
    int s, d, nx;
    bit lt, gt, clr, oor, trip;
    s  = l + r;
    d  = (l > r) ? l - r : r - l;
    lt = s < LO;
    gt = s > HI;
    nx = m_st; clr = 0; oor = 0; trip = 0;
    if (v) begin
      if (m_st == 0) begin
        if (gt) nx = 1;
      end else if (lt && m_db == OFF_DB - 1) nx = 0;
      else if (m_st == 1) begin
        if (d > s / 4) clr = 1;
        else if (m_tmr == T - 1) nx = 2;
      end else if (d > s - s / 16) nx = 1;
`ifdef LD_FAULT_CHK_EN
      oor  = (l == 0) || (l == 4095) || (r == 0) || (r == 4095);
      trip = oor && (m_fc + 1 >= F_N) && (m_st != 0);
      if (m_flt || trip) nx = 0;
      m_flt = oor ? (m_flt || trip) : 1'b0;
      m_fc  = oor ? ((m_fc < F_N) ? m_fc + 1 : F_N) : 0;
`endif
      m_db = ((nx != m_st) || !lt) ? 0 : ((m_db < OFF_DB) ? m_db + 1 : OFF_DB);
    end
    m_tmr = (((nx == 1) && (m_st != 1)) || clr) ? 0 : ((m_tmr < T - 1) ? m_tmr + 1 : m_tmr);
    m_st  = nx;
  endfunction

  function automatic logic [4:0] exp_vec();
    logic [1:0] s2;
    s2 = m_st[1:0];
    return {m_flt, s2, (m_st == 0), (m_st == 2)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(int'(lft), int'(rght), vld);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    lft = '0; rght = '0; vld = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    vecs++;
    if (obs !== 5'b00010) begin errs++; $display("FAIL reset_async got=%b exp=%b", obs, 5'b00010); end
    for (int i = 0; i < 3; i++) begin
      vld = 1'(i); lft = 12'h150; rght = 12'h150;
      step();
      vecs++;
      if (obs !== 5'b00010) begin errs++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs, 5'b00010); end
    end
    lft = '0; rght = '0; vld = 1'b1;
    rst_n = 1'b1;
    step();
    vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL reset_release got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_settle();
    int w_cyc;
    lft = 12'h150; rght = 12'h150; vld = 1'b1;
    step();
    vecs++;
    if (steer_state !== 2'd1) begin errs++; $display("FAIL settle_enter_wait got=%0d exp=1", steer_state); end
    w_cyc = cyc;
    for (int i = 0; i < T + 100 && en_steer !== 1'b1; i++) begin
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL settle cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
    vecs++;
    if (cyc - w_cyc !== T) begin errs++; $display("FAIL settle_latency got=%0d exp=%0d", cyc - w_cyc, T); end
  endtask

  task automatic test_async_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    vecs++;
    if (obs !== 5'b00010) begin errs++; $display("FAIL async_reset got=%b exp=%b", obs, 5'b00010); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL async_reset_hold got=%b exp=%b", obs, exp_vec()); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wait_imbalance();
    int last;
    lft = 12'h200; rght = 12'h0A0; vld = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL wait_imb cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
    last = cyc;
    lft = 12'h150; rght = 12'h150;
    for (int i = 0; i < T + 100 && en_steer !== 1'b1; i++) begin
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL wait_resettle cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
    vecs++;
    if (cyc - last !== T) begin errs++; $display("FAIL wait_imb_latency got=%0d exp=%0d", cyc - last, T); end
  endtask

  task automatic test_steer_imbalance_and_strobe();
    int c, k, exp_rise;
    lft = 12'h290; rght = 12'h010; vld = 1'b1;
    step();
    vecs++;
    if (obs !== 5'b00100) begin errs++; $display("FAIL steer_imb got=%b exp=%b", obs, 5'b00100); end
    c = cyc;
    lft = 12'h150; rght = 12'h150;
    k = T;
    while (k % 4 != 1) k++;
    exp_rise = c + k;
    for (int i = 0; i < T + 100 && en_steer !== 1'b1; i++) begin
      vld = (((cyc + 1 - c) % 4) == 1);
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL strobe cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
    vecs++;
    if (cyc !== exp_rise) begin errs++; $display("FAIL strobe_rise got=%0d exp=%0d", cyc, exp_rise); end
    vld = 1'b1;
  endtask

  task automatic test_debounce();
    int s, l;
    vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lft = (i < 3) ? 12'h050 : 12'h150; rght = lft;
      step();
      vecs++;
      if (obs !== 5'b01001) begin errs++; $display("FAIL debounce_short i=%0d got=%b exp=%b", i, obs, 5'b01001); end
    end
    lft = 12'h050; rght = 12'h050;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (obs !== ((i < 3) ? 5'b01001 : 5'b00010)) begin
        errs++; $display("FAIL debounce_off i=%0d got=%b exp=%b", i, obs, (i < 3) ? 5'b01001 : 5'b00010);
      end
    end
    lft = 12'h150; rght = 12'h150;
    for (int i = 0; i < T + 100 && en_steer !== 1'b1; i++) begin
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL debounce_resettle cyc=%0d got=%b exp=%b", cyc, obs, exp_vec()); end
    end
    for (int i = 0; i < 300; i++) begin
      s = (i < 20) ? 'h200 : int'($urandom_range(LO, HI));
      l = s / 2 + int'($urandom_range(0, 16)) - 8;
      lft = 12'(l); rght = 12'(s - l);
      vld = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      vecs++;
      if (obs !== 5'b01001) begin errs++; $display("FAIL band_hold cyc=%0d got=%b exp=%b", cyc, obs, 5'b01001); end
    end
  endtask

  task automatic test_fault();
    logic [4:0] e8, e9, e10;
`ifdef LD_FAULT_CHK_EN
    e8 = 5'b10010; e9 = 5'b00010; e10 = 5'b00100;
`else
    e8 = 5'b01001; e9 = 5'b01001; e10 = 5'b01001;
`endif
    lft = 12'hFFF; rght = 12'h100; vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vecs++;
      if (obs !== ((i < 7) ? 5'b01001 : e8)) begin
        errs++; $display("FAIL fault_trip i=%0d got=%b exp=%b", i, obs, (i < 7) ? 5'b01001 : e8);
      end
    end
    lft = 12'h150;
    step();
    vecs++;
    if (obs !== e9) begin errs++; $display("FAIL fault_clear got=%b exp=%b", obs, e9); end
    step();
    vecs++;
    if (obs !== e10) begin errs++; $display("FAIL fault_rewait got=%b exp=%b", obs, e10); end
    vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL fault_model got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_random();
    int s, l;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: begin lft = 12'($urandom); rght = 12'($urandom); end
        1: begin
          s = ($urandom_range(0, 1) != 0) ? LO + int'($urandom_range(0, 4)) - 2 : HI + int'($urandom_range(0, 4)) - 2;
          l = int'($urandom_range(0, s));
          lft = 12'(l); rght = 12'(s - l);
        end
        2: begin
          lft  = ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000;
          rght = ($urandom_range(0, 2) == 0) ? 12'h100 : 12'($urandom);
        end
        default: begin lft = 12'h150 + 12'($urandom_range(0, 15)); rght = 12'h150; end
      endcase
      vld = 1'($urandom_range(0, 1));
      step();
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL random cyc=%0d l=%h r=%h got=%b exp=%b", cyc, lft, rght, obs, exp_vec()); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_settle();
    test_async_reset();
    test_wait_imbalance();
    test_steer_imbalance_and_strobe();
    test_debounce();
    test_fault();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
